lemmings_walker_ctrl: RTL and testbench

- Parametrised successor of the two-state walk-left/walk-right walker FSM.
- Adds falling, digging and a configurable splat-on-long-fall rule.
- Leaf control block for one lemming agent; Moore outputs only; one clock domain.
- Used standalone in verilogmachine-style benches and replicated per agent in multi-agent tops.

---
 rtl/lemmings_pkg.sv | 22 ++
 rtl/lemmings_fall_timer.sv | 26 ++
 rtl/lemmings_walker_ctrl.sv | 64 ++++++
 tb/tb_lemmings_walker_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/lemmings_pkg.sv
// lemmings_pkg: shared state encoding, default parameters and helpers for the lemming walker.
package lemmings_pkg;

   typedef enum logic [2:0] {
      WALK_L,
      WALK_R,
      FALL_L,
      FALL_R,
      DIG_L,
      DIG_R,
      SPLAT
   } state_t;

   localparam int FALL_MAX_DEF = 20;
   localparam int CNT_W_DEF    = 8;

   // 1 = heading right, 0 = heading left (SPLAT reports left)
   function automatic logic dir_of(state_t s);
      return (s == WALK_R) || (s == FALL_R) || (s == DIG_R);
   endfunction

endpackage

// File: rtl/lemmings_fall_timer.sv
// lemmings_fall_timer: saturating count of completed fall cycles, flags when the survivable limit is reached.
module lemmings_fall_timer #(
   parameter int FALL_MAX = 20,
   parameter int CNT_W    = 8
) (
   input  logic clk,
   input  logic resetn,
   input  logic clr,
   input  logic inc,
   output logic over
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FALL_MAX);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!resetn || clr)
         r_cnt <= '0;
      else if (inc && r_cnt != '1)
         r_cnt <= r_cnt + 1'b1;
   end

   assign over = r_cnt >= LIMIT;

endmodule

// File: rtl/lemmings_walker_ctrl.sv
// lemmings_walker_ctrl: Moore FSM for one lemming - walk, dig, fall and splat on over-long falls.
module lemmings_walker_ctrl
   import lemmings_pkg::*;
#(
   parameter int FALL_MAX = FALL_MAX_DEF,
   parameter int CNT_W    = CNT_W_DEF,
   parameter bit DIG_EN   = 1'b1,
   parameter bit SPLAT_EN = 1'b1
) (
   input  logic clk,
   input  logic resetn,
   input  logic bump_left,
   input  logic bump_right,
   input  logic ground,
   input  logic dig,
   output logic walk_left,
   output logic walk_right,
   output logic aaah,
   output logic digging,
   output logic splat
);

   state_t r_state, w_next;
   logic   w_falling, w_over, w_dig;

   assign w_dig     = dig & DIG_EN;
   assign w_falling = (r_state == FALL_L) || (r_state == FALL_R);

   lemmings_fall_timer #(.FALL_MAX(FALL_MAX), .CNT_W(CNT_W)) u_timer (
      .clk    (clk),
      .resetn (resetn),
      .clr    (!w_falling),
      .inc    (w_falling && !ground),
      .over   (w_over)
   );

   // priority: losing ground beats dig, dig beats bump
   always_comb begin
      w_next = r_state;
      case (r_state)
         WALK_L:         w_next = !ground ? FALL_L : w_dig ? DIG_L : bump_left  ? WALK_R : WALK_L;
         WALK_R:         w_next = !ground ? FALL_R : w_dig ? DIG_R : bump_right ? WALK_L : WALK_R;
         DIG_L:          w_next = ground ? DIG_L : FALL_L;
         DIG_R:          w_next = ground ? DIG_R : FALL_R;
         FALL_L, FALL_R: w_next = !ground ? r_state : (SPLAT_EN && w_over) ? SPLAT : dir_of(r_state) ? WALK_R : WALK_L;
         SPLAT:          w_next = SPLAT;
         default:        w_next = WALK_L;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         r_state <= WALK_L;
      else
         r_state <= w_next;
   end

   assign walk_left  = r_state == WALK_L;
   assign walk_right = r_state == WALK_R;
   assign aaah       = w_falling;
   assign digging    = (r_state == DIG_L) || (r_state == DIG_R);
   assign splat      = r_state == SPLAT;

endmodule

// File: tb/tb_lemmings_walker_ctrl.sv
// tb_lemmings_walker_ctrl: directed vector table plus hand sequences for falls, splat, dig-disable and saturation.
module tb_lemmings_walker_ctrl;

   localparam logic [7:0] WL = 8'b10000;
   localparam logic [7:0] WR = 8'b01000;
   localparam logic [7:0] FA = 8'b00100;
   localparam logic [7:0] DG = 8'b00010;
   localparam logic [7:0] SP = 8'b00001;

   typedef struct {
      logic       rn, bl, br, g, d;
      logic [7:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic resetn, bump_left, bump_right, ground, dig;
   logic wl [4];
   logic wr [4];
   logic aa [4];
   logic dg [4];
   logic sp [4];
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t tv[$];

   always #5 clk = ~clk;

   lemmings_walker_ctrl d0 (.clk(clk), .resetn(resetn), .bump_left(bump_left), .bump_right(bump_right),
      .ground(ground), .dig(dig), .walk_left(wl[0]), .walk_right(wr[0]), .aaah(aa[0]), .digging(dg[0]), .splat(sp[0]));
   lemmings_walker_ctrl #(.DIG_EN(1'b0)) d1 (.clk(clk), .resetn(resetn), .bump_left(bump_left), .bump_right(bump_right),
      .ground(ground), .dig(dig), .walk_left(wl[1]), .walk_right(wr[1]), .aaah(aa[1]), .digging(dg[1]), .splat(sp[1]));
   lemmings_walker_ctrl #(.CNT_W(5)) d2 (.clk(clk), .resetn(resetn), .bump_left(bump_left), .bump_right(bump_right),
      .ground(ground), .dig(dig), .walk_left(wl[2]), .walk_right(wr[2]), .aaah(aa[2]), .digging(dg[2]), .splat(sp[2]));
   lemmings_walker_ctrl #(.CNT_W(5), .SPLAT_EN(1'b0)) d3 (.clk(clk), .resetn(resetn), .bump_left(bump_left), .bump_right(bump_right),
      .ground(ground), .dig(dig), .walk_left(wl[3]), .walk_right(wr[3]), .aaah(aa[3]), .digging(dg[3]), .splat(sp[3]));

   function automatic logic [7:0] outs(int i);
      return {3'b000, wl[i], wr[i], aa[i], dg[i], sp[i]};
   endfunction

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic step(logic rn, logic bl, logic br, logic g, logic d);
      resetn = rn; bump_left = bl; bump_right = br; ground = g; dig = d;
      @(posedge clk);
      #1;
   endtask

   task automatic add(logic rn, logic bl, logic br, logic g, logic d, logic [7:0] exp);
      vec_t v;
      v.rn = rn; v.bl = bl; v.br = br; v.g = g; v.d = d; v.exp = exp;
      tv.push_back(v);
   endtask

   task automatic do_reset();
      step(0, 1, 1, 1, 0);
      step(0, 1, 1, 1, 0);
      step(1, 0, 0, 1, 0);
   endtask

   // n cycles of no ground, checking d0 screams on every one of them
   task automatic fall(int n, string tag);
      for (int i = 0; i < n; i++) begin
         step(1, 1, 1, 0, 0);
         chk($sformatf("%s_aaah%0d", tag, i), outs(0), FA);
      end
   endtask

   initial begin
      add(0,1,1,1,0,WL); add(0,1,1,1,0,WL); add(1,0,0,1,0,WL); add(1,1,0,1,0,WR);
      add(1,0,0,1,0,WR); add(1,1,1,1,0,WL); add(1,0,1,1,0,WL); add(1,1,0,1,0,WR);
      add(1,1,0,1,0,WR); add(1,1,1,0,0,FA); add(1,1,1,0,0,FA); add(1,1,1,0,1,FA);
      add(1,1,1,0,0,FA); add(1,1,1,0,0,FA); add(1,0,0,1,0,WR); add(1,0,0,1,1,DG);
      add(1,1,1,1,0,DG); add(1,0,0,0,0,FA); add(1,0,0,1,0,WR); add(1,0,0,0,1,FA);
      add(1,0,0,1,0,WR); add(1,0,1,1,1,DG); add(1,0,0,0,0,FA); add(1,0,0,1,0,WR);
      add(1,0,1,1,0,WL); add(1,0,0,1,1,DG); add(1,1,0,1,0,DG); add(1,0,0,0,0,FA);
      add(1,0,0,1,0,WL);
      foreach (tv[i]) begin
         step(tv[i].rn, tv[i].bl, tv[i].br, tv[i].g, tv[i].d);
         chk($sformatf("vec%0d", i), outs(0), tv[i].exp);
      end
      // longest survivable fall
      do_reset();
      fall(20, "f20");
      step(1, 0, 0, 1, 0);
      chk("f20_land_d0", outs(0), WL);
      chk("f20_land_d2", outs(2), WL);
      // one cycle too long: splat, then absorbing under random inputs
      fall(21, "f21");
      step(1, 0, 0, 1, 0);
      chk("f21_land", outs(0), SP);
      for (int i = 0; i < 50; i++) begin
         step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         chk($sformatf("splat_hold%0d", i), outs(0), SP);
      end
      step(0, 0, 0, 0, 0);
      chk("splat_reset", outs(0), WL);
      // reset mid-fall must clear the counter
      do_reset();
      fall(16, "mid");
      chk("mid_cnt", 8'(d0.u_timer.r_cnt), 8'd15);
      step(0, 0, 0, 0, 0);
      chk("mid_reset", outs(0), WL);
      step(1, 0, 0, 1, 0);
      fall(20, "post");
      step(1, 0, 0, 1, 0);
      chk("post_land", outs(0), WL);
      // dig enabled vs disabled
      do_reset();
      step(1, 0, 0, 1, 1);
      chk("dig_d0", outs(0), DG);
      chk("dig_off_d1", outs(1), WL);
      step(1, 1, 0, 1, 0);
      chk("dig_bump_ign", outs(0), DG);
      step(1, 0, 0, 0, 0);
      chk("dig_fall", outs(0), FA);
      step(1, 0, 0, 1, 0);
      chk("dig_land", outs(0), WL);
      // saturation with a narrow counter
      do_reset();
      fall(40, "sat");
      chk("sat_cnt_d2", 8'(d2.u_timer.r_cnt), 8'd31);
      chk("sat_cnt_d3", 8'(d3.u_timer.r_cnt), 8'd31);
      step(1, 0, 0, 1, 0);
      chk("sat_d0", outs(0), SP);
      chk("sat_d2", outs(2), SP);
      chk("sat_nosplat_d3", outs(3), WL);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
